// File: rtl/keypad_scanner_if.sv
// Key-event channel from the keypad scanner to its consumer.
// The scanner is the master: it publishes key_code/key_valid/key_down/overrun
// and receives key_ack from the consumer.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_down,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_down,
    input  overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Rotates a one-hot drive across the four scan lines, samples the synchronized
// row returns at the end of each step, classifies every 4-step frame as
// NONE / KEY(c) / MULTI, debounces press and release over DEBOUNCE frames and
// hands one key code per distinct press to the consumer via valid/ack.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,  // cycles per scan line, 4..65535
  parameter int unsigned DEBOUNCE = 4      // matching frames to accept, 1..15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          rows_i,
  output logic [3:0]          lines_o,
  keypad_scanner_if.master    kev
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD}       state_e;
  typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_e;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB      = 4'(DEBOUNCE);

  // Row synchronizer
  logic [3:0] rows_s1_q, rows_s2_q;

  // Scan sequencing
  logic [15:0]     div_q;
  logic [1:0]      step_q;
  logic [3:0]      lines_q;
  logic [2:0][3:0] samp_q;   // samples of steps 0..2; step 3 is taken live
  logic            step_last;
  logic            frame_end;

  // Frame classification
  logic [3:0][3:0] frm;
  logic [2:0]      n_act;
  logic [1:0]      act_line;
  logic [3:0]      act_rows;
  logic [1:0]      row_idx;
  logic [3:0]      frame_code;
  frame_e          frame_cls;

  // Debounce FSM and registered outputs
  state_e     state_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;
  logic [3:0] cand_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_down_q;
  logic       overrun_q;
  logic       accept;

  // Two-flop synchronizer: raw rows are asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_s1_q <= '0;
      rows_s2_q <= '0;
    end else begin
      rows_s1_q <= rows_i;
      rows_s2_q <= rows_s1_q;
    end
  end

  assign step_last = (div_q == DIV_LAST);
  assign frame_end = step_last && (step_q == 2'd3);

  // Step timer, one-hot line rotation and per-step row sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      step_q  <= '0;
      lines_q <= 4'b0001;
      samp_q  <= '0;
    end else if (step_last) begin
      div_q   <= '0;
      step_q  <= step_q + 2'd1;
      lines_q <= {lines_q[2:0], lines_q[3]};
      case (step_q)
        2'd0:    samp_q[0] <= rows_s2_q;
        2'd1:    samp_q[1] <= rows_s2_q;
        2'd2:    samp_q[2] <= rows_s2_q;
        default: ;
      endcase
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  // The step-3 sample is the live synchronizer output on the frame-end cycle
  assign frm = {rows_s2_q, samp_q};

  // Classify the frame: exactly one active line carrying exactly one row is a KEY
  always_comb begin
    n_act    = '0;
    act_line = '0;
    act_rows = '0;
    row_idx  = '0;
    for (int l = 0; l < 4; l++) begin
      if (|frm[l]) begin
        n_act    = n_act + 3'd1;
        act_line = 2'(l);
        act_rows = frm[l];
      end
    end
    for (int r = 0; r < 4; r++) begin
      if (act_rows[r]) row_idx = 2'(r);
    end
    frame_code = {act_line, row_idx};
    if (n_act == 3'd0)
      frame_cls = FR_NONE;
    else if (n_act == 3'd1 && $onehot(act_rows))
      frame_cls = FR_KEY;
    else
      frame_cls = FR_MULTI;
  end

  assign cnt_inc = cnt_q + 4'd1;

  // A press is accepted on the frame end that completes the debounce run
  always_comb begin
    accept = 1'b0;
    if (frame_end && frame_cls == FR_KEY) begin
      case (state_q)
        IDLE:    accept = (DEB == 4'd1);
        CONFIRM: accept = (frame_code == cand_q) && (cnt_inc == DEB);
        default: accept = 1'b0;
      endcase
    end
  end

  // Debounce FSM with registered key outputs and the valid/ack handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (accept) begin
      // An accept overrides a same-cycle ack; only an unacked pending key overruns
      cand_q      <= frame_code;
      key_code_q  <= frame_code;
      key_valid_q <= 1'b1;
      key_down_q  <= 1'b1;
      if (key_valid_q && !kev.key_ack) overrun_q <= 1'b1;
      state_q     <= HELD;
      cnt_q       <= '0;
    end else begin
      if (key_valid_q && kev.key_ack) key_valid_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          IDLE: begin
            if (frame_cls == FR_KEY) begin
              cand_q  <= frame_code;
              cnt_q   <= 4'd1;
              state_q <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (frame_cls == FR_KEY && frame_code == cand_q) begin
              cnt_q <= cnt_inc;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            // Release needs DEBOUNCE consecutive empty frames
            if (frame_cls == FR_NONE) begin
              if (cnt_inc == DEB) begin
                key_down_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= IDLE;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign lines_o       = lines_q;
  assign kev.key_code  = key_code_q;
  assign kev.key_valid = key_valid_q;
  assign kev.key_down  = key_down_q;
  assign kev.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frame).
// A behavioural keypad drives rows from the pressed-key set and the scan lines.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  lines;
  logic [15:0] pressed = '0;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rows_i (rows),
    .lines_o(lines),
    .kev    (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: key c = {line, row} connects line c/4 to row c%4
  always_comb begin
    rows = '0;
    for (int c = 0; c < 16; c++)
      if (pressed[c] && lines[c / 4]) rows[c % 4] = 1'b1;
  end

  // Edges since reset release; frame ends fall on multiples of 16
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 16 != 0) @(negedge clk);
  endtask

  task automatic ack_pulse();
    kif.key_ack = 1'b1;
    step(1);
    kif.key_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_lines;
    rst_n = 1'b0;
    kif.key_ack = 1'b0;
    pressed = '0;
    step(3);
    checks++;
    if (lines !== 4'b0001 || kif.key_code !== 4'h0 || kif.key_valid !== 1'b0 ||
        kif.key_down !== 1'b0 || kif.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: lines=%b code=%h valid=%b down=%b ovr=%b exp 0001/0/0/0/0",
               lines, kif.key_code, kif.key_valid, kif.key_down, kif.overrun);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(1);
      exp_lines = 4'b0001 << ((cyc / 4) % 4);
      checks++;
      if (lines !== exp_lines) begin
        errors++;
        $display("FAIL idle_lines: cyc=%0d got %b exp %b", cyc, lines, exp_lines);
      end
      checks++;
      if ({kif.key_valid, kif.key_down, kif.overrun} !== 3'b000) begin
        errors++;
        $display("FAIL idle_flags: cyc=%0d got v/d/o=%b exp 000", cyc,
                 {kif.key_valid, kif.key_down, kif.overrun});
      end
    end
  endtask

  task automatic test_press();
    int   rises;
    logic prev;
    align();
    pressed[9] = 1'b1;
    step(47);
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL press_early: valid got %b exp 0", kif.key_valid);
    end
    step(1);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h9 || kif.key_down !== 1'b1) begin
      errors++;
      $display("FAIL press_accept: valid=%b code=%h down=%b exp 1/9/1",
               kif.key_valid, kif.key_code, kif.key_down);
    end
    step(10);
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++; $display("FAIL press_hold_valid: got %b exp 1", kif.key_valid);
    end
    ack_pulse();
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL press_ack: valid got %b exp 0", kif.key_valid);
    end
    rises = 0;
    prev  = kif.key_valid;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (kif.key_valid && !prev) rises++;
      prev = kif.key_valid;
    end
    checks++;
    if (rises != 0 || kif.key_down !== 1'b1) begin
      errors++;
      $display("FAIL press_single_event: rises=%0d down=%b exp 0/1", rises, kif.key_down);
    end
    align();
    pressed = '0;
    step(47);
    checks++;
    if (kif.key_down !== 1'b1) begin
      errors++; $display("FAIL release_early: down got %b exp 1", kif.key_down);
    end
    step(1);
    checks++;
    if (kif.key_down !== 1'b0) begin
      errors++; $display("FAIL release: down got %b exp 0", kif.key_down);
    end
  endtask

  task automatic test_ghost();
    align();
    pressed[0]  = 1'b1;
    pressed[15] = 1'b1;
    step(64);
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_down !== 1'b0) begin
      errors++;
      $display("FAIL ghost_multi: valid=%b down=%b exp 0/0", kif.key_valid, kif.key_down);
    end
    pressed[15] = 1'b0;
    step(47);
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL ghost_early: valid got %b exp 0", kif.key_valid);
    end
    step(1);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h0) begin
      errors++;
      $display("FAIL ghost_accept: valid=%b code=%h exp 1/0", kif.key_valid, kif.key_code);
    end
    ack_pulse();
    align();
    pressed = '0;
    step(48);
    checks++;
    if (kif.key_down !== 1'b0 || kif.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ghost_release: down=%b valid=%b exp 0/0", kif.key_down, kif.key_valid);
    end
  endtask

  task automatic test_bounce();
    align();
    for (int rep = 0; rep < 4; rep++) begin
      pressed[0] = 1'b1;
      step(16);
      pressed[0] = 1'b0;
      step(16);
      checks++;
      if (kif.key_valid !== 1'b0) begin
        errors++; $display("FAIL bounce_rep%0d: valid got %b exp 0", rep, kif.key_valid);
      end
    end
    pressed[0] = 1'b1;
    step(47);
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL bounce_stable_early: valid got %b exp 0", kif.key_valid);
    end
    step(1);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h0) begin
      errors++;
      $display("FAIL bounce_stable: valid=%b code=%h exp 1/0", kif.key_valid, kif.key_code);
    end
    ack_pulse();
    align();
    pressed = '0;
    step(48);
    checks++;
    if (kif.key_down !== 1'b0) begin
      errors++; $display("FAIL bounce_release: down got %b exp 0", kif.key_down);
    end
  endtask

  task automatic test_overrun();
    align();
    pressed[5] = 1'b1;
    step(48);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h5) begin
      errors++;
      $display("FAIL ovr_first: valid=%b code=%h exp 1/5", kif.key_valid, kif.key_code);
    end
    pressed = '0;
    step(48);
    checks++;
    if (kif.key_down !== 1'b0 || kif.key_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_release: down=%b valid=%b exp 0/1", kif.key_down, kif.key_valid);
    end
    pressed[15] = 1'b1;
    step(47);
    checks++;
    if (kif.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_early: overrun got %b exp 0", kif.overrun);
    end
    step(1);
    checks++;
    if (kif.key_code !== 4'hF || kif.key_valid !== 1'b1 || kif.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: code=%h valid=%b ovr=%b exp F/1/1",
               kif.key_code, kif.key_valid, kif.overrun);
    end
    pressed = '0;
    step(48);
  endtask

  task automatic test_reset_mid();
    align();
    pressed[6] = 1'b1;
    step(40);
    rst_n = 1'b0;
    #1;
    checks++;
    if (lines !== 4'b0001 || kif.key_code !== 4'h0 || kif.key_valid !== 1'b0 ||
        kif.key_down !== 1'b0 || kif.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: lines=%b code=%h valid=%b down=%b ovr=%b exp 0001/0/0/0/0",
               lines, kif.key_code, kif.key_valid, kif.key_down, kif.overrun);
    end
    step(2);
    rst_n = 1'b1;
    step(47);
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_down !== 1'b0) begin
      errors++;
      $display("FAIL reset_refill_early: valid=%b down=%b exp 0/0", kif.key_valid, kif.key_down);
    end
    step(1);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h6 || kif.key_down !== 1'b1) begin
      errors++;
      $display("FAIL reset_refill: valid=%b code=%h down=%b exp 1/6/1",
               kif.key_valid, kif.key_code, kif.key_down);
    end
    ack_pulse();
    align();
    pressed = '0;
    step(48);
  endtask

  task automatic test_overrun_ack();
    align();
    pressed[5] = 1'b1;
    step(48);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h5) begin
      errors++;
      $display("FAIL ack_first: valid=%b code=%h exp 1/5", kif.key_valid, kif.key_code);
    end
    pressed = '0;
    step(48);
    pressed[15] = 1'b1;
    step(47);
    kif.key_ack = 1'b1;
    step(1);
    kif.key_ack = 1'b0;
    checks++;
    if (kif.key_code !== 4'hF || kif.key_valid !== 1'b1 || kif.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_same_cycle: code=%h valid=%b ovr=%b exp F/1/0",
               kif.key_code, kif.key_valid, kif.overrun);
    end
    step(1);
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++; $display("FAIL ack_same_cycle_hold: valid got %b exp 1", kif.key_valid);
    end
    ack_pulse();
    checks++;
    if (kif.key_valid !== 1'b0 || kif.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: valid=%b ovr=%b exp 0/0", kif.key_valid, kif.overrun);
    end
    pressed = '0;
  endtask

  initial begin
    kif.key_ack = 1'b0;
    test_reset();
    test_press();
    test_ghost();
    test_bounce();
    test_overrun();
    test_reset_mid();
    test_overrun_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Active scanner for the 4x4 matrix keypad: drives one scan line at a time, samples the four return rows, debounces, and delivers one 4-bit key code per distinct keypress through a valid/ack handshake. It sits between the keypad pins and the controller logic. It replaces free-running combinational decoding of static line/row pairs with a clocked, glitch-free key event stream.

## Interface
- SCAN_DIV, 1000: clock cycles each scan line is driven; legal range 4..65535.
- DEBOUNCE, 4: consecutive identical scan frames needed to accept a press or a release; legal range 1..15.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rows  input  4  raw row returns, active-high, asynchronous to clk.
- lines  output  4  one-hot scan drive, active-high.
- key_code  output  4  code of the last accepted key: {line_index[1:0], row_index[1:0]}.
- key_valid  output  1  new key_code pending; held until acknowledged.
- key_ack  input  1  consumer acknowledge; consumed only while key_valid=1.
- key_down  output  1  level: an accepted key is currently held.
- overrun  output  1  sticky: a press was accepted while key_valid was still pending.

## Operation
- rows pass through a 2-flop synchronizer before any use.
- Scan step:
  - lines holds one bit for SCAN_DIV cycles, rotating 0001→0010→0100→1000→0001.
  - Synchronized rows are sampled on the last cycle of each step.
- Frame: 4 steps, 4*SCAN_DIV cycles. Frame result at end of the 1000 step:
  - NONE: all four samples are 0.
  - KEY(c): exactly one sample has exactly one bit set, and all other samples are 0. c = {line index, row index}; line index 0 = lines bit 0.
  - MULTI: anything else (ghosting, two keys). MULTI never matches a KEY candidate and never counts as NONE.
- State machine, evaluated once per frame end:
  - IDLE: on KEY(c), latch candidate=c, cnt=1. If DEBOUNCE=1, accept immediately; otherwise go to CONFIRM.
  - CONFIRM: on KEY(same c), cnt+1; when cnt=DEBOUNCE, accept. Any other result returns to IDLE with cnt=0.
  - Accept: key_code←c, key_valid←1, key_down←1, go to HELD.
    - If key_valid was already 1 and not acked this cycle, set overrun.
  - HELD: on NONE, cnt+1; when cnt=DEBOUNCE, key_down←0 and go to IDLE. KEY or MULTI resets cnt=0 and stays in HELD. No new press can be accepted in HELD.
- Handshake:
  - key_ack=1 while key_valid=1 clears key_valid on the next edge.
  - key_ack while key_valid=0 is ignored.
  - Ack on the same cycle as an accept: the accept wins. key_valid stays 1, key_code takes the new value, overrun is not set.
- overrun is cleared only by reset.

## Timing
- Reset values: lines=4'b0001, key_code=0, key_valid=0, key_down=0, overrun=0. State IDLE, all counters 0, scan step counter 0.
- Reset mid-operation: immediate return to the reset values above. A pending key is lost without an event.
- A row change reaches the sampler 2 cycles after its clk edge. It must be present ≥2 cycles before the sample cycle to count in that frame.
- key_valid and key_down rise on the clock edge following the frame-end sample of the DEBOUNCE-th matching frame.
- Press latency from a stable press: between (DEBOUNCE-1)*4*SCAN_DIV+3 and DEBOUNCE*4*SCAN_DIV+3 cycles.
- key_down falls on the edge following the DEBOUNCE-th consecutive NONE frame end.
- lines changes only at step boundaries and is never zero or multi-hot.

## Test plan
Parameters: SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
- Reset, then idle 64 cycles → lines rotates 0001,0010,0100,1000 every 4 cycles. key_valid, key_down and overrun all stay 0.
- Model key (line 2, row 1): rows=4'b0010 while lines=0100, held stable → key_code=4'h9 and key_valid=1 after 3 KEY frames. key_valid stays 1 until key_ack pulses, then falls on the next edge. Only one event for a 200-cycle hold.
- Bounce: key (0,0) present for 1 frame, absent 1 frame, repeated ×4 → no key_valid. Then stable for 3 frames → key_code=4'h0 accepted.
- Ghost: keys (0,0) and (3,3) held together → MULTI every frame, no key_valid. Release (3,3) → key_code=0 after 3 frames.
- Overrun: accept key 5, never ack, release 3 frames, press key 15 → key_code=4'hF, key_valid=1, overrun=1. Repeat with key_ack on the accept cycle → overrun stays 0.
- Assert rst_n=0 in CONFIRM with cnt=2 → all outputs at reset values immediately. After release of reset, a held key needs a full 3 frames again.
